// File: rtl/fmult_seq.sv
// Control sequencer for the bit-serial floating-point predictor multiplier.
// Each product runs SETUP..SERIAL; the frame ends with a one-cycle DONE pulse.
module fmult_seq #(
  parameter int N_PROD   = 8,
  parameter int N_B      = 6,
  parameter int SER_BITS = 16,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] op_sel,
  output logic             op_is_a,
  output logic             INIT_SR,
  output logic             SHIFT_EXP,
  output logic             SHIFT_MANT,
  output logic             LD_OUT_SR,
  output logic             prod_valid,
  output logic             ser_valid,
  output logic [3:0]       ser_idx,
  output logic             ser_last
);

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    INIT,
    HOLD,
    GAP,
    SHIFT,
    LOAD,
    SERIAL,
    DONE
  } state_t;

  localparam logic [3:0]       SHIFT_LAST = 4'd11;
  localparam logic [3:0]       SER_LAST   = 4'(SER_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_PROD - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
  logic [3:0]       cntNext;
  logic [IDX_W-1:0] idxNext;

  assign cntNext = cnt + 4'd1;
  assign idxNext = idx + 1'b1;

  function automatic logic isA(input logic [IDX_W-1:0] i);
    return int'(i) >= N_B;
  endfunction

  // Outputs are set for the state being entered, so every value is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_sel     <= '0;
      op_is_a    <= 1'b0;
      INIT_SR    <= 1'b0;
      SHIFT_EXP  <= 1'b0;
      SHIFT_MANT <= 1'b0;
      LD_OUT_SR  <= 1'b0;
      prod_valid <= 1'b0;
      ser_valid  <= 1'b0;
      ser_idx    <= '0;
      ser_last   <= 1'b0;
    end else begin
      done       <= 1'b0;
      INIT_SR    <= 1'b0;
      SHIFT_EXP  <= 1'b0;
      SHIFT_MANT <= 1'b0;
      LD_OUT_SR  <= 1'b0;
      prod_valid <= 1'b0;
      ser_valid  <= 1'b0;
      ser_idx    <= '0;
      ser_last   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            idx     <= '0;
            busy    <= 1'b1;
            op_sel  <= '0;
            op_is_a <= isA('0);
            INIT_SR <= 1'b1;
          end
        end

        SETUP: begin
          state      <= INIT;
          INIT_SR    <= 1'b1;
          SHIFT_EXP  <= 1'b1;
          SHIFT_MANT <= 1'b1;
        end

        INIT: begin
          state   <= HOLD;
          INIT_SR <= 1'b1;
        end

        HOLD: begin
          state <= GAP;
        end

        // Entering SHIFT at p=0, which is an even phase for both strobes.
        GAP: begin
          state      <= SHIFT;
          cnt        <= '0;
          SHIFT_EXP  <= 1'b1;
          SHIFT_MANT <= 1'b1;
        end

        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            state     <= LOAD;
            LD_OUT_SR <= 1'b1;
          end else begin
            cnt        <= cntNext;
            SHIFT_MANT <= ~cntNext[0];
            SHIFT_EXP  <= ~cntNext[0] && (cntNext < 4'd10);
          end
        end

        LOAD: begin
          state      <= SERIAL;
          cnt        <= '0;
          ser_valid  <= 1'b1;
          prod_valid <= 1'b1;
          ser_last   <= (SER_BITS == 1);
        end

        SERIAL: begin
          if (cnt != SER_LAST) begin
            cnt       <= cntNext;
            ser_valid <= 1'b1;
            ser_idx   <= cntNext;
            ser_last  <= (cntNext == SER_LAST);
          end else if (idx == IDX_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            op_sel  <= '0;
            op_is_a <= 1'b0;
          end else begin
            state   <= SETUP;
            idx     <= idxNext;
            op_sel  <= idxNext;
            op_is_a <= isA(idxNext);
            INIT_SR <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmult_seq.sv
// Bench for fmult_seq: per-cycle scoreboard against a timeline model, driven
// from a table of frame scenarios, on a default and a reduced-parameter instance.
module tb_fmult_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startA = 1'b0;
  logic startB = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] opSel;
    logic       opIsA;
    logic       initSr;
    logic       shExp;
    logic       shMant;
    logic       ldOut;
    logic       prodValid;
    logic       serValid;
    logic [3:0] serIdx;
    logic       serLast;
  } outV_t;

  // DUT A: defaults
  logic busyA, doneA, opIsAA, initA, expA, mantA, ldA, pvA, svA, slA;
  logic [2:0] opSelA;
  logic [3:0] siA;
  fmult_seq dutA (
    .clk(clk), .reset(reset), .start(startA),
    .busy(busyA), .done(doneA), .op_sel(opSelA), .op_is_a(opIsAA),
    .INIT_SR(initA), .SHIFT_EXP(expA), .SHIFT_MANT(mantA), .LD_OUT_SR(ldA),
    .prod_valid(pvA), .ser_valid(svA), .ser_idx(siA), .ser_last(slA)
  );

  // DUT B: reduced variant
  logic busyB, doneB, opIsAB, initB, expB, mantB, ldB, pvB, svB, slB;
  logic [2:0] opSelB;
  logic [3:0] siB;
  fmult_seq #(.N_PROD(3), .N_B(2), .SER_BITS(4), .IDX_W(3)) dutB (
    .clk(clk), .reset(reset), .start(startB),
    .busy(busyB), .done(doneB), .op_sel(opSelB), .op_is_a(opIsAB),
    .INIT_SR(initB), .SHIFT_EXP(expB), .SHIFT_MANT(mantB), .LD_OUT_SR(ldB),
    .prod_valid(pvB), .ser_valid(svB), .ser_idx(siB), .ser_last(slB)
  );

  int checks = 0;
  int errors = 0;
  int gc = -1;
  int base = 0;
  int fsA = -1;
  int fsB = -1;
  int selDut = 0;
  int doneCnt = 0;
  int firstDone = -1;
  int expEdges = 0;
  int mantEdges = 0;
  logic prevExp = 1'b0;
  logic prevMant = 1'b0;

  outV_t qA[$];
  outV_t qB[$];

  // Expected outputs t cycles after the cycle in which start was accepted.
  function automatic outV_t expAt(input int t, input int nProd, input int nB, input int serBits);
    outV_t e;
    int per, k, o, p, j;
    e = '0;
    per = 17 + serBits;
    if (t >= 1 && t <= nProd * per) begin
      k = (t - 1) / per;
      o = (t - 1) % per;
      e.busy  = 1'b1;
      e.opSel = 3'(k);
      e.opIsA = (k >= nB);
      if (o <= 2) e.initSr = 1'b1;
      if (o == 1) begin
        e.shExp  = 1'b1;
        e.shMant = 1'b1;
      end
      if (o >= 4 && o <= 15) begin
        p = o - 4;
        e.shMant = (p % 2 == 0);
        e.shExp  = (p % 2 == 0) && (p < 10);
      end
      if (o == 16) e.ldOut = 1'b1;
      if (o >= 17) begin
        j = o - 17;
        e.serValid  = 1'b1;
        e.serIdx    = 4'(j);
        e.prodValid = (j == 0);
        e.serLast   = (j == serBits - 1);
      end
    end else if (t == nProd * per + 1) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic outV_t expFor(input int fs, input int c, input int nProd, input int nB, input int serBits);
    if (fs < 0) return '0;
    return expAt(c - fs, nProd, nB, serBits);
  endfunction

  function automatic bit isIdle(input int fs, input int c, input int nProd, input int serBits);
    return (fs < 0) || ((c - fs) >= nProd * (17 + serBits) + 2);
  endfunction

  // One clock cycle: push this cycle's expected outputs, then drive inputs.
  task automatic tick(input logic rs, input logic stA, input logic stB);
    @(posedge clk);
    #1;
    gc++;
    qA.push_back(expFor(fsA, gc, 8, 6, 16));
    qB.push_back(expFor(fsB, gc, 3, 2, 4));
    reset  = rs;
    startA = stA;
    startB = stB;
    if (rs) begin
      fsA = -1;
      fsB = -1;
    end else begin
      if (stA && isIdle(fsA, gc, 8, 16)) fsA = gc;
      if (stB && isIdle(fsB, gc, 3, 4)) fsB = gc;
    end
  endtask

  always @(negedge clk) begin
    outV_t ev, av;
    if (qA.size() > 0) begin
      ev = qA.pop_front();
      av = {busyA, doneA, opSelA, opIsAA, initA, expA, mantA, ldA, pvA, svA, siA, slA};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL dutA_outputs cycle=%0d actual=%h required=%h", gc - base, av, ev);
      end
    end
    if (qB.size() > 0) begin
      ev = qB.pop_front();
      av = {busyB, doneB, opSelB, opIsAB, initB, expB, mantB, ldB, pvB, svB, siB, slB};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL dutB_outputs cycle=%0d actual=%h required=%h", gc - base, av, ev);
      end
    end
    if ((selDut == 0 && doneA === 1'b1) || (selDut == 1 && doneB === 1'b1)) begin
      doneCnt++;
      if (firstDone < 0) firstDone = gc - base;
    end
    if (expA === 1'b1 && prevExp === 1'b0) expEdges++;
    if (mantA === 1'b1 && prevMant === 1'b0) mantEdges++;
    prevExp  = expA;
    prevMant = mantA;
  end

  typedef struct {
    string name;
    int    dut;
    bit    startInReset;
    int    s0, s1, s2, s3;
    int    holdUntil;
    int    rstAt;
    int    len;
    int    expDone;
    int    expDoneCnt;
    int    expExpEdges;
    int    expMantEdges;
  } scen_t;

  scen_t scen[6];

  task automatic setScen(input int i, input string nm, input int dut, input bit sir,
                         input int s0, input int s1, input int s2, input int s3,
                         input int hold, input int rstAt, input int len,
                         input int eDone, input int eCnt, input int eExp, input int eMant);
    scen[i].name = nm;          scen[i].dut = dut;          scen[i].startInReset = sir;
    scen[i].s0 = s0;            scen[i].s1 = s1;            scen[i].s2 = s2;
    scen[i].s3 = s3;            scen[i].holdUntil = hold;   scen[i].rstAt = rstAt;
    scen[i].len = len;          scen[i].expDone = eDone;    scen[i].expDoneCnt = eCnt;
    scen[i].expExpEdges = eExp; scen[i].expMantEdges = eMant;
  endtask

  initial begin
    //        name              dut sir  s0   s1   s2   s3  hold rst  len  done cnt exp mant
    setScen(0, "full_frame",     0, 0,   0,  -1,  -1,  -1,  -1,  -1, 272, 265, 1,  48, 56);
    setScen(1, "reset_held",     0, 1,  -1,  -1,  -1,  -1, 266,  -1, 300, 265, 1,  -1, -1);
    setScen(2, "start_busy",     0, 0,   0,   1, 100, 264,  -1,  -1, 272, 265, 1,  48, 56);
    setScen(3, "mid_reset",      0, 0,   0, 112,  -1,  -1,  -1, 109, 380, 377, 1,  -1, -1);
    setScen(4, "back_to_back",   0, 0,   0, 266,  -1,  -1,  -1,  -1, 535, 265, 2,  96, 112);
    setScen(5, "variant_3_2_4",  1, 0,   0,  -1,  -1,  -1,  -1,  -1,  70,  64, 1,  -1, -1);

    for (int i = 0; i < 6; i++) begin
      selDut    = scen[i].dut;
      doneCnt   = 0;
      firstDone = -1;
      expEdges  = 0;
      mantEdges = 0;
      for (int r = 0; r < 3; r++)
        tick(1'b1, scen[i].startInReset && selDut == 0, scen[i].startInReset && selDut == 1);
      base = gc + 1;
      for (int c = 0; c < scen[i].len; c++) begin
        logic st, rs;
        st = (c == scen[i].s0) || (c == scen[i].s1) || (c == scen[i].s2) ||
             (c == scen[i].s3) || (c <= scen[i].holdUntil);
        rs = (c == scen[i].rstAt);
        tick(rs, st && selDut == 0, st && selDut == 1);
      end
      @(negedge clk);
      #1;

      checks++;
      if (doneCnt != scen[i].expDoneCnt) begin
        errors++;
        $display("FAIL %s done_count actual=%0d required=%0d", scen[i].name, doneCnt, scen[i].expDoneCnt);
      end
      checks++;
      if (firstDone != scen[i].expDone) begin
        errors++;
        $display("FAIL %s first_done_cycle actual=%0d required=%0d", scen[i].name, firstDone, scen[i].expDone);
      end
      if (scen[i].expExpEdges >= 0) begin
        checks++;
        if (expEdges != scen[i].expExpEdges) begin
          errors++;
          $display("FAIL %s shift_exp_edges actual=%0d required=%0d", scen[i].name, expEdges, scen[i].expExpEdges);
        end
        checks++;
        if (mantEdges != scen[i].expMantEdges) begin
          errors++;
          $display("FAIL %s shift_mant_edges actual=%0d required=%0d", scen[i].name, mantEdges, scen[i].expMantEdges);
        end
      end
      $display("scenario %s: done_count=%0d first_done=%0d exp_edges=%0d mant_edges=%0d",
               scen[i].name, doneCnt, firstDone, expEdges, mantEdges);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
